tile_fetch_engine: RTL and testbench

// Responder side of the tile_start/tile_done handshake issued by the tile controller.
// On tile_start it latches the tile origin and IFM base address, then issues one read per in-bounds pixel.
// It writes the returned data into the tile-local buffer in row-major order and pulses tile_done when the tile is complete.

---
 rtl/tile_fetch_if.sv | 46 ++++
 rtl/tile_fetch_engine.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_tile_fetch_engine.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_fetch_if.sv
// tile_fetch_if: bundles the tile controller handshake, the external read port
// and the tile buffer write port of tile_fetch_engine.
// slave  = the fetch engine itself, master = whatever drives it (controller,
// memory and buffer side).
interface tile_fetch_if #(
    parameter int TILE_H     = 16,
    parameter int TILE_W     = 8,
    parameter int DATA_BYTES = 2
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int AW = $clog2(TILE_H * TILE_W);

    // tile controller side
    logic          tile_start;
    logic [15:0]   tile_x;
    logic [15:0]   tile_y;
    logic [31:0]   ifm_base_addr;
    logic [15:0]   H;
    logic [15:0]   W;
    logic          busy;
    logic          tile_done;
    // external read port
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [31:0]   rd_req_addr;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    // tile buffer write port
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;

    modport master (
        output tile_start, tile_x, tile_y, ifm_base_addr, H, W,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  busy, tile_done, rd_req_valid, rd_req_addr,
        input  buf_wr_en, buf_wr_addr, buf_wr_data
    );

    modport slave (
        input  tile_start, tile_x, tile_y, ifm_base_addr, H, W,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output busy, tile_done, rd_req_valid, rd_req_addr,
        output buf_wr_en, buf_wr_addr, buf_wr_data
    );
endinterface

// File: rtl/tile_fetch_engine.sv
// tile_fetch_engine: fetches one tile of pixels from the IFM through a
// valid/ready read port (in-order responses, bounded outstanding count) and
// writes them row-major into the tile-local buffer, then pulses tile_done.
// Optional feature macro: ZERO_PAD_EN -- when defined, a PAD state walks every
// tile position after the reads drain and writes 0 to positions outside the
// frame, so each tile produces exactly TILE_H*TILE_W buffer writes.
module tile_fetch_engine #(
    parameter int TILE_H          = 16,
    parameter int TILE_W          = 8,
    parameter int DATA_BYTES      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    tile_fetch_if.slave bus
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int AW = $clog2(TILE_H * TILE_W);
    localparam int RW = $clog2(TILE_H + 1);
    localparam int CW = $clog2(TILE_W + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN,
        S_DONE
`ifdef ZERO_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   tile_x_q, tile_x_d;
    logic [15:0]   tile_y_q, tile_y_d;
    logic [15:0]   h_q, h_d;
    logic [15:0]   w_q, w_d;
    logic [31:0]   base_q, base_d;
    logic [31:0]   stride_q, stride_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [CW-1:0] cols_q, cols_d;
    // request side position and address
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [31:0]   row_addr_q, row_addr_d;
    logic [31:0]   addr_q, addr_d;
    logic [OW-1:0] outst_q, outst_d;
    // response side position: row base (rr*TILE_W) and column rc
    logic [AW-1:0] rsp_base_q, rsp_base_d;
    logic [CW-1:0] rc_q, rc_d;
    // registered buffer write port
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
`ifdef ZERO_PAD_EN
    localparam logic [AW:0] PAD_END = (AW+1)'(TILE_H * TILE_W);
    logic [AW:0]   pad_idx_q, pad_idx_d;
    logic [RW-1:0] pad_r_q, pad_r_d;
    logic [CW-1:0] pad_c_q, pad_c_d;
`endif

    logic          req_valid;
    logic          accept;
    logic          rsp_take;
    logic [15:0]   h_left, w_left;
    logic [RW-1:0] rows_calc;
    logic [CW-1:0] cols_calc;

    assign req_valid = (state_q == S_ISSUE) && (outst_q != OW'(MAX_OUTSTANDING));
    assign accept    = req_valid && bus.rd_req_ready;
    // a response with nothing outstanding is stray and dropped
    assign rsp_take  = bus.rd_rsp_valid && (outst_q != '0);

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.tile_done    = (state_q == S_DONE);
    assign bus.rd_req_valid = req_valid;
    assign bus.rd_req_addr  = addr_q;
    assign bus.buf_wr_en    = wr_en_q;
    assign bus.buf_wr_addr  = wr_addr_q;
    assign bus.buf_wr_data  = wr_data_q;

    // Clip the tile against the frame edges using the latched origin and size.
    always_comb begin
        h_left = h_q - tile_y_q;
        w_left = w_q - tile_x_q;
        if (tile_y_q >= h_q)
            rows_calc = '0;
        else if (h_left > 16'(TILE_H))
            rows_calc = RW'(TILE_H);
        else
            rows_calc = h_left[RW-1:0];
        if (tile_x_q >= w_q)
            cols_calc = '0;
        else if (w_left > 16'(TILE_W))
            cols_calc = CW'(TILE_W);
        else
            cols_calc = w_left[CW-1:0];
    end

    // Next-state, request walk, outstanding count and buffer write generation.
    always_comb begin
        state_d    = state_q;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        h_d        = h_q;
        w_d        = w_q;
        base_d     = base_q;
        stride_d   = stride_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        r_d        = r_q;
        c_d        = c_q;
        row_addr_d = row_addr_q;
        addr_d     = addr_q;
        outst_d    = outst_q;
        rsp_base_d = rsp_base_q;
        rc_d       = rc_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef ZERO_PAD_EN
        pad_idx_d  = pad_idx_q;
        pad_r_d    = pad_r_q;
        pad_c_d    = pad_c_q;
`endif

        case ({accept, rsp_take})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        // Responses arrive in request order, so a simple row/column walk
        // recovers each pixel's buffer position.
        if (rsp_take) begin
            wr_en_d   = 1'b1;
            wr_addr_d = rsp_base_q + AW'(rc_q);
            wr_data_d = bus.rd_rsp_data;
            if (rc_q == cols_q - CW'(1)) begin
                rc_d       = '0;
                rsp_base_d = rsp_base_q + AW'(TILE_W);
            end else begin
                rc_d = rc_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.tile_start) begin
                    tile_x_d = bus.tile_x;
                    tile_y_d = bus.tile_y;
                    h_d      = bus.H;
                    w_d      = bus.W;
                    base_d   = bus.ifm_base_addr;
                    stride_d = 32'(bus.W) * 32'(DATA_BYTES);
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                rows_d     = rows_calc;
                cols_d     = cols_calc;
                r_d        = '0;
                c_d        = '0;
                row_addr_d = base_q;
                addr_d     = base_q;
                rsp_base_d = '0;
                rc_d       = '0;
`ifdef ZERO_PAD_EN
                pad_idx_d  = '0;
                pad_r_d    = '0;
                pad_c_d    = '0;
                state_d    = ((rows_calc == '0) || (cols_calc == '0)) ? S_PAD : S_ISSUE;
`else
                state_d    = ((rows_calc == '0) || (cols_calc == '0)) ? S_DONE : S_ISSUE;
`endif
            end
            S_ISSUE: begin
                if (accept) begin
                    if (c_q == cols_q - CW'(1)) begin
                        c_d        = '0;
                        row_addr_d = row_addr_q + stride_q;
                        addr_d     = row_addr_q + stride_q;
                        if (r_q == rows_q - RW'(1))
                            state_d = S_DRAIN;
                        else
                            r_d = r_q + RW'(1);
                    end else begin
                        c_d    = c_q + CW'(1);
                        addr_d = addr_q + 32'(DATA_BYTES);
                    end
                end
            end
            S_DRAIN: begin
`ifdef ZERO_PAD_EN
                if (outst_q == '0) state_d = S_PAD;
`else
                if (outst_q == '0) state_d = S_DONE;
`endif
            end
`ifdef ZERO_PAD_EN
            S_PAD: begin
                // One extra cycle at PAD_END lets the last pad write land
                // before tile_done.
                if (pad_idx_q == PAD_END) begin
                    state_d = S_DONE;
                end else begin
                    if ((pad_r_q >= rows_q) || (pad_c_q >= cols_q)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pad_idx_q[AW-1:0];
                        wr_data_d = '0;
                    end
                    pad_idx_d = pad_idx_q + (AW+1)'(1);
                    if (pad_c_q == CW'(TILE_W - 1)) begin
                        pad_c_d = '0;
                        pad_r_d = pad_r_q + RW'(1);
                    end else begin
                        pad_c_d = pad_c_q + CW'(1);
                    end
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any tile in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tile_x_q   <= '0;
            tile_y_q   <= '0;
            h_q        <= '0;
            w_q        <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            row_addr_q <= '0;
            addr_q     <= '0;
            outst_q    <= '0;
            rsp_base_q <= '0;
            rc_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef ZERO_PAD_EN
            pad_idx_q  <= '0;
            pad_r_q    <= '0;
            pad_c_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tile_x_q   <= tile_x_d;
            tile_y_q   <= tile_y_d;
            h_q        <= h_d;
            w_q        <= w_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            r_q        <= r_d;
            c_q        <= c_d;
            row_addr_q <= row_addr_d;
            addr_q     <= addr_d;
            outst_q    <= outst_d;
            rsp_base_q <= rsp_base_d;
            rc_q       <= rc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef ZERO_PAD_EN
            pad_idx_q  <= pad_idx_d;
            pad_r_q    <= pad_r_d;
            pad_c_q    <= pad_c_d;
`endif
        end
    end
endmodule

// File: tb/tb_tile_fetch_engine.sv
// tb_tile_fetch_engine: scoreboard bench. Each tile's expected reads and
// buffer writes are queued by the stimulus; a negedge monitor pops and
// compares them as the engine presents requests and writes.
module tb_tile_fetch_engine;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_fetch_if bus ();

    tile_fetch_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic [31:0] exp_addr[$];
    wr_t         exp_wr[$];
    logic [31:0] pend_q[$];
    logic [31:0] addr_log[$];
    int checks = 0;
    int errors = 0;
    int reads_seen = 0, writes_seen = 0, dones_seen = 0;
    int cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    bit hold = 0, rand_ready = 0;
    bit prev_stall = 0;
    logic [31:0] prev_addr = '0;

`ifdef ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rsp_of(input logic [31:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected reads (row-major, clipped to the frame) and writes for one tile.
    task automatic expect_tile(input int x, input int y, input int h, input int w,
                               input logic [31:0] base);
        int rows, cols;
        logic [31:0] a;
        wr_t e;
        rows = (y >= h) ? 0 : (((h - y) < 16) ? (h - y) : 16);
        cols = (x >= w) ? 0 : (((w - x) < 8) ? (w - x) : 8);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                a = base + 32'(r * w * 2 + c * 2);
                exp_addr.push_back(a);
                e.a = AW'(r * 8 + c);
                e.d = rsp_of(a);
                exp_wr.push_back(e);
            end
        end
        if (ZP) begin
            for (int p = 0; p < 128; p++) begin
                if ((p / 8 >= rows) || (p % 8 >= cols)) begin
                    e.a = AW'(p);
                    e.d = 16'h0000;
                    exp_wr.push_back(e);
                end
            end
        end
    endtask

    task automatic clear_counts();
        reads_seen = 0;
        writes_seen = 0;
        dones_seen = 0;
        addr_log.delete();
    endtask

    // Called just after a rising edge; returns one cycle later with tile_start low.
    task automatic start_tile(input logic [15:0] x, input logic [15:0] y,
                              input logic [31:0] base, input logic [15:0] h,
                              input logic [15:0] w);
        bus.tile_x = x;
        bus.tile_y = y;
        bus.ifm_base_addr = base;
        bus.H = h;
        bus.W = w;
        bus.tile_start = 1'b1;
        @(posedge clk); #1;
        bus.tile_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (dones_seen == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dones_seen == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no tile_done required=tile_done within %0d cycles", budget);
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic end_tile(input string tag, input int n_rd, input int n_wr);
        $display("tile %s reads=%0d writes=%0d dones=%0d", tag, reads_seen, writes_seen, dones_seen);
        chk({tag, "_reads"}, reads_seen, n_rd);
        chk({tag, "_writes"}, writes_seen, n_wr);
        chk({tag, "_dones"}, dones_seen, 1);
        chk({tag, "_reads_left"}, exp_addr.size(), 0);
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
        if (!ZP && n_wr > 0) chk({tag, "_done_gap"}, done_cyc - last_wr_cyc, 1);
    endtask

    // Memory model: one response per cycle, one cycle after acceptance.
    initial begin
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_data = '0;
        bus.rd_req_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.rd_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst && !hold && pend_q.size() > 0) begin
                bus.rd_rsp_valid = 1'b1;
                bus.rd_rsp_data = rsp_of(pend_q.pop_front());
            end else begin
                bus.rd_rsp_valid = 1'b0;
                bus.rd_rsp_data = '0;
            end
        end
    end

    // Monitor: compares every accepted request and buffer write in order.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.rd_req_valid), 1);
                    chk("stall_addr", bus.rd_req_addr, prev_addr);
                end
                prev_stall = bus.rd_req_valid && !bus.rd_req_ready;
                prev_addr = bus.rd_req_addr;
                if (bus.rd_req_valid && bus.rd_req_ready) begin
                    reads_seen++;
                    addr_log.push_back(bus.rd_req_addr);
                    pend_q.push_back(bus.rd_req_addr);
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read actual=0x%0h required=no read", bus.rd_req_addr);
                    end else begin
                        chk("read_addr", bus.rd_req_addr, exp_addr.pop_front());
                    end
                end
                if (bus.buf_wr_en) begin
                    writes_seen++;
                    last_wr_cyc = cyc;
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=addr 0x%0h required=no write", bus.buf_wr_addr);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", 32'(bus.buf_wr_addr), 32'(e.a));
                        chk("wr_data", 32'(bus.buf_wr_data), 32'(e.d));
                    end
                end
                if (bus.tile_done) begin
                    dones_seen++;
                    done_cyc = cyc;
                    chk("writes_left_at_done", exp_wr.size(), 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.tile_start = 1'b0;
        bus.tile_x = '0;
        bus.tile_y = '0;
        bus.ifm_base_addr = '0;
        bus.H = '0;
        bus.W = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.tile_done), 0);
        chk("rst_req_valid", 32'(bus.rd_req_valid), 0);
        chk("rst_req_addr", bus.rd_req_addr, 0);
        chk("rst_wr_en", 32'(bus.buf_wr_en), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full 16x8 tile at the frame origin; a second tile_start while busy is ignored.
        clear_counts();
        expect_tile(0, 0, 64, 64, 32'h0);
        start_tile(16'd0, 16'd0, 32'h0, 16'd64, 16'd64);
        @(negedge clk);
        chk("t1_valid_cycle1", 32'(bus.rd_req_valid), 0);
        chk("t1_busy_cycle1", 32'(bus.busy), 1);
        @(negedge clk);
        chk("t1_valid_cycle2", 32'(bus.rd_req_valid), 1);
        @(posedge clk); #1;
        start_tile(16'd8, 16'd16, 32'h1000, 16'd20, 16'd64);
        wait_done(2000);
        end_tile("full", 128, 128);
        chk("full_addr8", addr_log[8], 32'd128);
        chk("full_addr127", addr_log[127], 32'd1934);

        // Bottom-clipped tile: 4 rows x 8 cols.
        clear_counts();
        expect_tile(8, 16, 20, 64, 32'h1000);
        start_tile(16'd8, 16'd16, 32'h1000, 16'd20, 16'd64);
        wait_done(2000);
        end_tile("clip", 32, ZP ? 128 : 32);
        chk("clip_addr8", addr_log[8], 32'h1080);

        // Responses withheld: requests stop at the outstanding limit.
        clear_counts();
        hold = 1'b1;
        expect_tile(0, 0, 64, 64, 32'h0);
        start_tile(16'd0, 16'd0, 32'h0, 16'd64, 16'd64);
        repeat (12) @(negedge clk);
        chk("hold_reads", reads_seen, 4);
        chk("hold_valid_low", 32'(bus.rd_req_valid), 0);
        hold = 1'b0;
        @(negedge clk);
        chk("hold_valid_rsp_cycle", 32'(bus.rd_req_valid), 0);
        @(negedge clk);
        chk("hold_valid_resume", 32'(bus.rd_req_valid), 1);
        wait_done(2000);
        end_tile("hold", 128, 128);

        // Random backpressure on the request port.
        clear_counts();
        rand_ready = 1'b1;
        expect_tile(0, 0, 64, 64, 32'h200);
        start_tile(16'd0, 16'd0, 32'h200, 16'd64, 16'd64);
        wait_done(3000);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        end_tile("stall", 128, 128);

        // Tile entirely right of the frame.
        clear_counts();
        expect_tile(64, 0, 64, 64, 32'h0);
        start_tile(16'd64, 16'd0, 32'h0, 16'd64, 16'd64);
        @(negedge clk);
        chk("empty_done_cycle1", 32'(bus.tile_done), 0);
        if (!ZP) begin
            @(negedge clk);
            chk("empty_done_cycle2", 32'(bus.tile_done), 1);
        end
        wait_done(500);
        end_tile("empty", 0, ZP ? 128 : 0);

        // Reset in the middle of a tile, then a normal tile.
        clear_counts();
        expect_tile(0, 0, 64, 64, 32'h0);
        start_tile(16'd0, 16'd0, 32'h0, 16'd64, 16'd64);
        n = 0;
        while (reads_seen < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reads_reached", 32'(reads_seen >= 10), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_req_valid", 32'(bus.rd_req_valid), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_wr_en", 32'(bus.buf_wr_en), 0);
        chk("abort_done", 32'(bus.tile_done), 0);
        chk("abort_req_addr", bus.rd_req_addr, 0);
        exp_addr.delete();
        exp_wr.delete();
        pend_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("abort_no_done", dones_seen, 0);
        $display("tile abort reads=%0d writes=%0d dones=%0d", reads_seen, writes_seen, dones_seen);

        clear_counts();
        expect_tile(0, 0, 64, 64, 32'h0);
        start_tile(16'd0, 16'd0, 32'h0, 16'd64, 16'd64);
        wait_done(2000);
        end_tile("after_rst", 128, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
